// File: rtl/image_load_ctrl.sv
// Image load controller: accepts NPIX pixels into an image buffer, then
// streams the buffer out toward the conv layer with a 1-cycle read latency.
// Ports:
//   clk, reset           : clock, async active-high reset
//   load_req             : pulse that starts loading one image
//   img_valid/img_pixel  : pixel source; img_ready accepts in LOAD
//   store/pixel_out      : write strobe and data to the image buffer
//   store_finish         : buffer reports the image is complete
//   address/start        : buffer read address (0 = idle) and output enable
//   consumer_en          : downstream can take a feature this cycle
//   feat_valid           : buffer output feature valid (1 cycle after read)
//   busy/frame_done/err  : status, end-of-frame pulse, sticky store error
module image_load_ctrl #(
  parameter int NPIX = 784,
  parameter int AW   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_req,
  input  logic               img_valid,
  input  logic signed [15:0] img_pixel,
  output logic               img_ready,
  output logic               store,
  output logic signed [15:0] pixel_out,
  input  logic               store_finish,
  output logic [AW-1:0]      address,
  output logic               start,
  input  logic               consumer_en,
  output logic               feat_valid,
  output logic               busy,
  output logic               frame_done,
  output logic               err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  localparam logic [AW-1:0] NPIX_A = AW'(NPIX);
  localparam logic [AW-1:0] LIMIT  = AW'(NPIX + 2);
  localparam logic [AW-1:0] ONE    = AW'(1);

  state_t        state, state_n;
  logic [AW-1:0] count, count_n, count_inc;
  logic [AW-1:0] address_n;
  logic          err_n;

  assign count_inc = count + {{(AW-1){1'b0}}, img_valid};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      address    <= '0;
      err        <= 1'b0;
      feat_valid <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      address    <= address_n;
      err        <= err_n;
      // buffer data appears one cycle after the read is issued
      feat_valid <= (state == STREAM) && consumer_en;
    end
  end

  always_comb begin
    state_n    = state;
    count_n    = count;
    address_n  = address;
    err_n      = err;
    img_ready  = 1'b0;
    store      = 1'b0;
    pixel_out  = '0;
    start      = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (load_req) begin
          state_n = LOAD;
          count_n = '0;
          err_n   = 1'b0;
        end
      end
      LOAD: begin
        img_ready = 1'b1;
        store     = img_valid;
        pixel_out = img_pixel;
        count_n   = count_inc;
        if (store_finish) begin
          state_n   = STREAM;
          address_n = NPIX_A;
        end else if (count_inc == LIMIT) begin
          // buffer never confirmed the image: give up
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end
      STREAM: begin
        start = 1'b1;
        if (consumer_en) begin
          if (address <= ONE) begin
            state_n   = DRAIN;
            address_n = '0;
          end else begin
            address_n = address - ONE;
          end
        end
      end
      DRAIN: begin
        start     = 1'b1;
        address_n = '0;
        state_n   = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_n    = IDLE;
      end
      default: begin
        state_n   = IDLE;
        address_n = '0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/image_load_ctrl.md
IMAGE_LOAD_CTRL -- requirements
Module: image_load_ctrl

Interface
REQ-001 Parameter NPIX, default 784: pixels per image.
REQ-002 Parameter AW, default 16: width of the pixel counter and of the address bus.
REQ-003 Port clk, input, 1: the only clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high; clears all state immediately.
REQ-005 Port load_req, input, 1: one-cycle pulse requesting load and stream of one image.
REQ-006 Port img_valid, input, 1: the external pixel source holds a pixel.
REQ-007 Port img_pixel, input, 16 signed: pixel from the external source.
REQ-008 Port img_ready, output, 1: the controller accepts a pixel this cycle.
REQ-009 Port store, output, 1: write strobe to the image buffer.
REQ-010 Port pixel_out, output, 16 signed: pixel forwarded to the image buffer.
REQ-011 Port store_finish, input, 1: the image buffer reports that the image is stored.
REQ-012 Port address, output, AW: read address to the image buffer; 0 means idle.
REQ-013 Port start, output, 1: enables the image buffer output toward the conv layer.
REQ-014 Port consumer_en, input, 1: the downstream layer can take a feature this cycle.
REQ-015 Port feat_valid, output, 1: the buffer output feature is valid this cycle.
REQ-016 Port busy, output, 1: the FSM is not in IDLE.
REQ-017 Port frame_done, output, 1: one-cycle pulse when an image has been fully streamed.
REQ-018 Port err, output, 1: sticky flag, set when the buffer fails to report store_finish.

Function
REQ-019 The FSM shall have exactly these states: IDLE, LOAD, STREAM, DRAIN, DONE.
REQ-020 IDLE: on load_req=1 go to LOAD, clear the pixel count and clear err; load_req in any other state shall be ignored.
REQ-021 LOAD outputs: img_ready=1; store=img_valid (combinational); pixel_out=img_pixel.
REQ-022 LOAD counting: each cycle with img_valid=1 counts one accepted pixel.
REQ-023 Outside LOAD: img_ready=0, store=0, pixel_out=0.
REQ-024 LOAD exit on success: store_finish=1 sampled high moves the FSM to STREAM with address=NPIX on the next cycle.
REQ-025 LOAD exit on error: if the pixel count reaches NPIX+2 without store_finish, set err=1 and return to IDLE.
REQ-026 STREAM: start=1; address decrements by 1 on each cycle with consumer_en=1 and holds otherwise.
REQ-027 STREAM exit: the cycle that advances from address=1 moves the FSM to DRAIN with address=0.
REQ-028 DRAIN: start=1, address=0, lasts one cycle, then DONE.
REQ-029 DONE: frame_done=1 for exactly one cycle, start=0, then IDLE.
REQ-030 feat_valid shall be a register equal to (state==STREAM and consumer_en) from the previous cycle, because the buffer output has 1-cycle read latency.
REQ-031 Exactly NPIX feat_valid pulses shall occur per image, for buffer indices 0..NPIX-1 in order.
REQ-032 Stalls: consumer_en=0 for k cycles extends STREAM by k cycles and produces no duplicate feat_valid.
REQ-033 busy=1 in every state except IDLE.
REQ-034 Address arithmetic is unsigned AW-bit; address shall never wrap below 0.

Reset
REQ-035 While reset=1: state=IDLE, address=0, count=0, and all outputs 0 (start, store, img_ready, feat_valid, frame_done, busy, err, pixel_out).
REQ-036 Reset asserted in any state, including mid-LOAD or mid-STREAM, shall abort the operation with no frame_done pulse; after release the block waits for a new load_req.

Verification
REQ-037 Reset then load_req; img_valid=1 continuously; store_finish 1 cycle after the 784th store -> 784 store pulses, address 784..1, 784 feat_valid pulses, then one frame_done.
REQ-038 img_valid toggled 1/0 during LOAD -> store pulses only when img_valid=1, count=784 at exit, then normal streaming.
REQ-039 consumer_en=0 for 5 cycles while address=400 -> address holds at 400, feat_valid=0 for those cycles, total feat_valid count still 784.
REQ-040 store_finish never asserted -> err=1 after 786 accepted pixels, FSM in IDLE, busy=0; the next load_req clears err.
REQ-041 reset pulse while address=300 in STREAM -> all outputs 0 immediately, no frame_done; a new load_req completes normally.
REQ-042 load_req pulsed during STREAM -> ignored; exactly one frame_done for the current image.
